// File: rtl/usr_pkg.sv
// Shared constants for the universal shift register: mode codes, burst FSM
// state encoding and burst direction values.
package usr_pkg;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROTR = 3'b100;
  localparam logic [2:0] M_ROTL = 3'b101;
  localparam logic [2:0] M_ASHR = 3'b110;
  localparam logic [2:0] M_ZERO = 3'b111;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

endpackage

// File: rtl/usr_burst_ctl.sv
// Burst engine: on an accepted START, requests min(BLEN, WIDTH) shifts in the
// captured direction, then pulses done for one cycle.
module usr_burst_ctl
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic          bdir,
  input  logic [CW-1:0] blen,
  output logic          take,
  output logic          shift_en,
  output logic          dir,
  output logic          done,
  output logic [0:0]    state
);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic          done_q, done_d;

  // START is a single-cycle request with no ready: it is taken only when idle
  // and BLEN is non-zero; otherwise it is dropped and the caller's MODE applies.
  assign take = (state_q == S_IDLE) && start && (blen != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (take) begin
          state_d = S_SHIFT;
          dir_d   = bdir;
          cnt_d   = (blen > CW'(WIDTH)) ? CW'(WIDTH) : blen;
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_q - CW'(1);
        // Exit on the last shift so the counter never wraps below zero.
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_R;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign shift_en = (state_q == S_SHIFT);
  assign dir      = dir_q;
  assign done     = done_q;
  assign state    = state_q;

endmodule

// File: rtl/univ_shift_reg_n.sv
// WIDTH-bit universal shift register with eight idle-time modes and an
// autonomous multi-position burst shift.
module univ_shift_reg_n
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             LIN,
  input  logic             RIN,
  input  logic             START,
  input  logic             BDIR,
  input  logic [CW-1:0]    BLEN,
  output logic [WIDTH-1:0] Q,
  output logic             SOUT_R,
  output logic             SOUT_L,
  output logic             BUSY,
  output logic             DONE
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             take;
  logic             shift_en;
  logic             dir;
  logic [0:0]       burst_state;

  usr_burst_ctl #(
    .WIDTH(WIDTH),
    .CW   (CW)
  ) u_burst_ctl (
    .clk     (clk),
    .clr     (CLR),
    .start   (START),
    .bdir    (BDIR),
    .blen    (BLEN),
    .take    (take),
    .shift_en(shift_en),
    .dir     (dir),
    .done    (DONE),
    .state   (burst_state)
  );

  // A running burst owns the register; on the accepting edge Q just holds.
  always_comb begin
    q_d = q_q;
    if (shift_en) begin
      q_d = (dir == DIR_L) ? {q_q[WIDTH-2:0], LIN} : {RIN, q_q[WIDTH-1:1]};
    end else if (!take) begin
      case (MODE)
        M_HOLD:  q_d = q_q;
        M_SHR:   q_d = {RIN, q_q[WIDTH-1:1]};
        M_SHL:   q_d = {q_q[WIDTH-2:0], LIN};
        M_LOAD:  q_d = D;
        M_ROTR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
        M_ROTL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        M_ASHR:  q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        M_ZERO:  q_d = '0;
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (CLR) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q      = q_q;
  assign SOUT_R = q_q[0];
  assign SOUT_L = q_q[WIDTH-1];
  assign BUSY   = (burst_state == S_SHIFT);

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Bench for univ_shift_reg_n: directed vector table, hand-written burst corner
// sequences, then random traffic against an arithmetic reference model.
module tb_univ_shift_reg_n;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk;
  logic          CLR;
  logic [2:0]    MODE;
  logic [W-1:0]  D;
  logic          LIN;
  logic          RIN;
  logic          START;
  logic          BDIR;
  logic [CW-1:0] BLEN;
  logic [W-1:0]  Q;
  logic          SOUT_R;
  logic          SOUT_L;
  logic          BUSY;
  logic          DONE;

  int n_checks;
  int n_fail;

  univ_shift_reg_n #(.WIDTH(W)) dut (
    .clk   (clk),
    .CLR   (CLR),
    .MODE  (MODE),
    .D     (D),
    .LIN   (LIN),
    .RIN   (RIN),
    .START (START),
    .BDIR  (BDIR),
    .BLEN  (BLEN),
    .Q     (Q),
    .SOUT_R(SOUT_R),
    .SOUT_L(SOUT_L),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Integer view of the register plus "shifts remaining" bookkeeping.
  int unsigned m_q;
  int          m_rem;
  bit          m_busy;
  bit          m_done;
  bit          m_dir;
  localparam int unsigned MASK = (1 << W) - 1;
  localparam int unsigned MSB  = 1 << (W - 1);

  function automatic int unsigned apply_mode(int unsigned v, logic [2:0] m,
                                             int unsigned d, bit lin, bit rin);
    case (m)
      3'd1:    return (v / 2) + (rin ? MSB : 0);
      3'd2:    return ((v * 2) & MASK) + (lin ? 1 : 0);
      3'd3:    return d & MASK;
      3'd4:    return (v / 2) + ((v % 2) * MSB);
      3'd5:    return ((v * 2) & MASK) + (v / MSB);
      3'd6:    return (v / 2) + (v & MSB);
      3'd7:    return 0;
      default: return v;
    endcase
  endfunction

  always @(posedge clk) begin
    if (CLR) begin
      m_q <= 0; m_rem <= 0; m_busy <= 0; m_done <= 0; m_dir <= 0;
    end else if (m_busy) begin
      m_q    <= apply_mode(m_q, m_dir ? 3'd2 : 3'd1, 0, LIN, RIN);
      m_rem  <= m_rem - 1;
      m_busy <= (m_rem > 1);
      m_done <= (m_rem == 1);
    end else begin
      m_done <= 0;
      if (START && int'(BLEN) > 0) begin
        m_busy <= 1;
        m_dir  <= BDIR;
        m_rem  <= (int'(BLEN) > W) ? W : int'(BLEN);
      end else begin
        m_q <= apply_mode(m_q, MODE, int'(D), LIN, RIN);
      end
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic clr, input logic [2:0] mode, input logic [W-1:0] d,
                       input logic lin, input logic rin, input logic start,
                       input logic bdir, input logic [CW-1:0] blen);
    CLR = clr; MODE = mode; D = d; LIN = lin; RIN = rin;
    START = start; BDIR = bdir; BLEN = blen;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          clr;
    logic [2:0]    mode;
    logic [W-1:0]  d;
    logic          lin;
    logic          rin;
    logic          start;
    logic          bdir;
    logic [CW-1:0] blen;
    logic [W-1:0]  exp_q;
    logic          exp_busy;
    logic          exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic clr, input logic [2:0] mode, input logic [W-1:0] d,
                         input logic lin, input logic rin, input logic start,
                         input logic bdir, input logic [CW-1:0] blen,
                         input logic [W-1:0] eq, input logic eb, input logic ed);
    vec_t v;
    v.clr = clr; v.mode = mode; v.d = d; v.lin = lin; v.rin = rin;
    v.start = start; v.bdir = bdir; v.blen = blen;
    v.exp_q = eq; v.exp_busy = eb; v.exp_done = ed;
    vecs.push_back(v);
  endtask

  logic [W-1:0] exp_q[$];
  int           busy_cycles;
  bit           seen_done;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    drive(1, 3'd0, 8'h00, 0, 0, 0, 0, 4'd0);

    //      clr mode  d      lin rin st dir blen  q      busy done
    add_vec(1, 3'd0, 8'h00, 0, 0, 0, 0, 4'd0, 8'h00, 0, 0);
    add_vec(1, 3'd0, 8'h00, 0, 0, 0, 0, 4'd0, 8'h00, 0, 0);
    add_vec(0, 3'd3, 8'hA5, 0, 0, 0, 0, 4'd0, 8'hA5, 0, 0);
    add_vec(0, 3'd0, 8'h00, 0, 0, 0, 0, 4'd0, 8'hA5, 0, 0);
    add_vec(0, 3'd0, 8'h00, 0, 0, 0, 0, 4'd0, 8'hA5, 0, 0);
    add_vec(0, 3'd0, 8'h00, 0, 0, 0, 0, 4'd0, 8'hA5, 0, 0);
    add_vec(0, 3'd1, 8'h00, 0, 1, 0, 0, 4'd0, 8'hD2, 0, 0);
    add_vec(0, 3'd3, 8'hA5, 0, 0, 0, 0, 4'd0, 8'hA5, 0, 0);
    add_vec(0, 3'd2, 8'h00, 0, 0, 0, 0, 4'd0, 8'h4A, 0, 0);
    add_vec(0, 3'd3, 8'hA5, 0, 0, 0, 0, 4'd0, 8'hA5, 0, 0);
    add_vec(0, 3'd4, 8'h00, 0, 1, 0, 0, 4'd0, 8'hD2, 0, 0);
    add_vec(0, 3'd3, 8'hA5, 0, 0, 0, 0, 4'd0, 8'hA5, 0, 0);
    add_vec(0, 3'd5, 8'h00, 0, 0, 0, 0, 4'd0, 8'h4B, 0, 0);
    add_vec(0, 3'd3, 8'h85, 0, 0, 0, 0, 4'd0, 8'h85, 0, 0);
    add_vec(0, 3'd6, 8'h00, 0, 0, 0, 0, 4'd0, 8'hC2, 0, 0);
    add_vec(0, 3'd7, 8'h00, 0, 0, 0, 0, 4'd0, 8'h00, 0, 0);
    add_vec(0, 3'd3, 8'hF0, 0, 0, 0, 0, 4'd0, 8'hF0, 0, 0);
    add_vec(0, 3'd2, 8'h00, 0, 0, 1, 0, 4'd3, 8'hF0, 1, 0);
    add_vec(0, 3'd2, 8'h00, 0, 0, 0, 0, 4'd0, 8'h78, 1, 0);
    add_vec(0, 3'd2, 8'h00, 0, 0, 0, 0, 4'd0, 8'h3C, 1, 0);
    add_vec(0, 3'd2, 8'h00, 0, 0, 0, 0, 4'd0, 8'h1E, 0, 1);
    add_vec(0, 3'd0, 8'h00, 0, 0, 0, 0, 4'd0, 8'h1E, 0, 0);
    add_vec(0, 3'd1, 8'h00, 0, 1, 1, 0, 4'd0, 8'h8F, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr, vecs[i].mode, vecs[i].d, vecs[i].lin, vecs[i].rin,
            vecs[i].start, vecs[i].bdir, vecs[i].blen);
      tick();
      check($sformatf("vec%0d_q", i), 32'(Q), 32'(vecs[i].exp_q));
      check($sformatf("vec%0d_busy", i), 32'(BUSY), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_done", i), 32'(DONE), 32'(vecs[i].exp_done));
    end
    check("sout_r_8f", 32'(SOUT_R), 32'd1);
    check("sout_l_8f", 32'(SOUT_L), 32'd1);

    // BLEN above WIDTH saturates: exactly W left shifts of LIN=1 into 81.
    drive(0, 3'd3, 8'h81, 0, 0, 0, 0, 4'd0); tick();
    drive(0, 3'd0, 8'h00, 1, 0, 1, 1, 4'd15); tick();
    drive(0, 3'd0, 8'h00, 1, 0, 0, 0, 4'd0);
    busy_cycles = 0;
    seen_done   = 0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      if (BUSY) busy_cycles++;
      tick();
      seen_done = DONE;
    end
    check("sat_done_seen", 32'(seen_done), 32'd1);
    check("sat_busy_cycles", 32'(busy_cycles), 32'd8);
    check("sat_q", 32'(Q), 32'hFF);

    // START while busy is ignored; START in the DONE cycle starts a new burst.
    exp_q = '{8'h0F, 8'h87, 8'hC3, 8'hC3, 8'h86};
    drive(0, 3'd3, 8'h0F, 0, 0, 0, 0, 4'd0); tick();
    drive(0, 3'd0, 8'h00, 0, 1, 1, 0, 4'd2); tick();
    check("bb_q0", 32'(Q), 32'(exp_q.pop_front()));
    drive(0, 3'd0, 8'h00, 0, 1, 1, 1, 4'd5); tick();
    check("bb_q1", 32'(Q), 32'(exp_q.pop_front()));
    check("bb_retrig_busy", 32'(BUSY), 32'd1);
    drive(0, 3'd0, 8'h00, 0, 1, 0, 0, 4'd0); tick();
    check("bb_q2", 32'(Q), 32'(exp_q.pop_front()));
    check("bb_done1", 32'(DONE), 32'd1);
    check("bb_busy_off", 32'(BUSY), 32'd0);
    drive(0, 3'd0, 8'h00, 0, 0, 1, 1, 4'd1); tick();
    check("bb_q3", 32'(Q), 32'(exp_q.pop_front()));
    check("bb_second_busy", 32'(BUSY), 32'd1);
    check("bb_done_cleared", 32'(DONE), 32'd0);
    drive(0, 3'd0, 8'h00, 0, 0, 0, 0, 4'd0); tick();
    check("bb_q4", 32'(Q), 32'(exp_q.pop_front()));
    check("bb_done2", 32'(DONE), 32'd1);

    // CLR in the second busy cycle of a BLEN=5 burst aborts with no DONE.
    drive(0, 3'd3, 8'hFF, 0, 0, 0, 0, 4'd0); tick();
    drive(0, 3'd0, 8'h00, 0, 0, 1, 0, 4'd5); tick();
    drive(0, 3'd0, 8'h00, 0, 0, 0, 0, 4'd0); tick();
    check("abort_q_mid", 32'(Q), 32'h7F);
    drive(1, 3'd0, 8'h00, 0, 0, 0, 0, 4'd0); tick();
    check("abort_q", 32'(Q), 32'h00);
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_done", 32'(DONE), 32'd0);
    drive(0, 3'd0, 8'h00, 0, 0, 0, 0, 4'd0);
    seen_done = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (DONE) seen_done = 1;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);

    // Random traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 49) == 0, 3'($urandom_range(0, 7)), 8'($urandom),
            1'($urandom), 1'($urandom), $urandom_range(0, 5) == 0,
            1'($urandom), 4'($urandom_range(0, 15)));
      tick();
      check("rnd_q", 32'(Q), 32'(m_q));
      check("rnd_busy", 32'(BUSY), 32'(m_busy));
      check("rnd_done", 32'(DONE), 32'(m_done));
      check("rnd_sout_r", 32'(SOUT_R), 32'(m_q % 2));
      check("rnd_sout_l", 32'(SOUT_L), 32'(m_q / MSB));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
